// File: rtl/dac_wave_gen.sv
// dac_wave_gen: dual-channel saw/square/triangle/DC sample source feeding a 12-bit offset-binary DAC
module dac_wave_gen #(
    parameter int PHASE_W  = 24,
    parameter int TICK_DIV = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               sync,
    input  logic [PHASE_W-1:0] FTW_A,
    input  logic [PHASE_W-1:0] FTW_B,
    input  logic [1:0]         WAVE_A,
    input  logic [1:0]         WAVE_B,
    input  logic [3:0]         ATT_A,
    input  logic [3:0]         ATT_B,
    output logic [11:0]        DATA_A,
    output logic [11:0]        DATA_B,
    output logic               data_valid
);
    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [PHASE_W-1:0] phase_a_q, phase_a_d, phase_b_q, phase_b_d;
    logic [1:0]         wave_a_q, wave_a_d, wave_b_q, wave_b_d;
    logic [3:0]         att_a_q, att_a_d, att_b_q, att_b_d;
    logic [11:0]        data_a_q, data_a_d, data_b_q, data_b_d;
    logic               pend_q, pend_d, valid_q, valid_d, tick, fire;

    function automatic logic [11:0] shape(input logic [PHASE_W-1:0] ph, input logic [1:0] wv, input logic [3:0] at);
        logic [11:0]       w;
        logic signed [12:0] s;
        w = wv == 2'b00 ? ph[PHASE_W-1 -: 12] :
            wv == 2'b01 ? {12{ph[PHASE_W-1]}} :
            wv == 2'b10 ? (ph[PHASE_W-1] ? ~ph[PHASE_W-2 -: 12] : ph[PHASE_W-2 -: 12]) :
            12'h800;
        s = $signed({1'b0, w}) - 13'sd2048;
        return at >= 4'd12 ? 12'h800 : 12'((s >>> at) + 13'sd2048);
    endfunction

    assign DATA_A     = data_a_q;
    assign DATA_B     = data_b_q;
    assign data_valid = valid_q;

    // Next state: divider, phase step and setting capture on tick, sample output one edge later; sync overrides all
    always_comb begin
        tick      = enable && div_q == DIV_W'(TICK_DIV - 1);
        fire      = pend_q && !sync;
        div_d     = (sync || tick) ? '0 : enable ? div_q + DIV_W'(1) : div_q;
        phase_a_d = sync ? '0 : tick ? phase_a_q + FTW_A : phase_a_q;
        phase_b_d = sync ? '0 : tick ? phase_b_q + FTW_B : phase_b_q;
        wave_a_d  = tick ? WAVE_A : wave_a_q;
        wave_b_d  = tick ? WAVE_B : wave_b_q;
        att_a_d   = tick ? ATT_A : att_a_q;
        att_b_d   = tick ? ATT_B : att_b_q;
        pend_d    = tick && !sync;
        valid_d   = fire;
        data_a_d  = fire ? shape(phase_a_q, wave_a_q, att_a_q) : data_a_q;
        data_b_d  = fire ? shape(phase_b_q, wave_b_q, att_b_q) : data_b_q;
    end

    // State registers; reset parks outputs at midscale and drops any pending update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            phase_a_q <= '0;
            phase_b_q <= '0;
            wave_a_q  <= 2'b00;
            wave_b_q  <= 2'b00;
            att_a_q   <= 4'd0;
            att_b_q   <= 4'd0;
            data_a_q  <= 12'h800;
            data_b_q  <= 12'h800;
            pend_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            phase_a_q <= phase_a_d;
            phase_b_q <= phase_b_d;
            wave_a_q  <= wave_a_d;
            wave_b_q  <= wave_b_d;
            att_a_q   <= att_a_d;
            att_b_q   <= att_b_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            pend_q    <= pend_d;
            valid_q   <= valid_d;
        end
    end
endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: directed checks of dac_wave_gen with TICK_DIV=4
module tb_dac_wave_gen;
    logic        clk = 1'b0;
    logic        rst, enable, sync;
    logic [23:0] ftw_a, ftw_b;
    logic [1:0]  wave_a, wave_b;
    logic [3:0]  att_a, att_b;
    logic [11:0] data_a, data_b;
    logic        data_valid;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dac_wave_gen #(.PHASE_W(24), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sync(sync),
        .FTW_A(ftw_a), .FTW_B(ftw_b), .WAVE_A(wave_a), .WAVE_B(wave_b),
        .ATT_A(att_a), .ATT_B(att_b), .DATA_A(data_a), .DATA_B(data_b),
        .data_valid(data_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        step();
        while (!data_valid && n < 20) begin
            step();
            n++;
        end
        check("valid_seen", data_valid, 1'b1);
    endtask

    task automatic restart();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic expect_a(input string tag, input logic [11:0] exp);
        int n;
        wait_valid(n);
        check(tag, data_a, exp);
    endtask

    task automatic expect_b(input string tag, input logic [11:0] exp);
        int n;
        wait_valid(n);
        check(tag, data_b, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n, seen;
        logic [11:0] tri_exp [10] = '{12'h200, 12'h400, 12'h600, 12'h800, 12'hA00,
                                      12'hC00, 12'hE00, 12'hFFF, 12'hDFF, 12'hBFF};
        rst = 1'b0; enable = 1'b0; sync = 1'b0;
        ftw_a = '0; ftw_b = '0; wave_a = 2'b00; wave_b = 2'b00; att_a = 4'd0; att_b = 4'd0;
        repeat (3) step();
        check("rst_data_a", data_a, 12'h800);
        check("rst_data_b", data_b, 12'h800);
        check("rst_valid", data_valid, 1'b0);
        rst = 1'b1;
        seen = 0;
        repeat (10) begin
            step();
            seen += int'(data_valid);
        end
        check("disabled_no_valid", seen, 0);
        check("disabled_data_a", data_a, 12'h800);

        ftw_a = 24'h001000; ftw_b = 24'h001000;
        enable = 1'b1;
        wait_valid(n);
        check("first_latency", n, 5);
        check("saw_1", data_a, 12'h001);
        wait_valid(n);
        check("saw_gap_2", n, 4);
        check("saw_2", data_a, 12'h002);
        wait_valid(n);
        check("saw_gap_3", n, 4);
        check("saw_3", data_a, 12'h003);

        step();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        check("sync_no_valid", data_valid, 1'b0);
        check("sync_hold_a", data_a, 12'h003);
        wait_valid(n);
        check("sync_gap", n, 4);
        check("sync_data_a", data_a, 12'h001);
        check("sync_data_b", data_b, 12'h001);

        enable = 1'b0;
        seen = 0;
        repeat (8) begin
            step();
            seen += int'(data_valid);
        end
        check("hold_no_valid", seen, 0);
        check("hold_data_a", data_a, 12'h001);
        enable = 1'b1;

        ftw_a = 24'h800000;
        restart();
        expect_a("wrap_0", 12'h800);
        expect_a("wrap_1", 12'h000);
        expect_a("wrap_2", 12'h800);
        expect_a("wrap_3", 12'h000);

        wave_a = 2'b01; att_a = 4'd1;
        restart();
        expect_a("sq_att1_0", 12'hBFF);
        expect_a("sq_att1_1", 12'h400);
        expect_a("sq_att1_2", 12'hBFF);

        att_a = 4'd12;
        restart();
        expect_a("sq_att12_0", 12'h800);
        expect_a("sq_att12_1", 12'h800);

        wave_a = 2'b11; att_a = 4'd0;
        restart();
        expect_a("dc", 12'h800);

        ftw_b = 24'h100000; wave_b = 2'b10; att_b = 4'd0;
        restart();
        for (int i = 0; i < 10; i++) expect_b($sformatf("tri_%0d", i), tri_exp[i]);

        rst = 1'b0;
        #1;
        check("async_rst_a", data_a, 12'h800);
        check("async_rst_b", data_b, 12'h800);
        check("async_rst_valid", data_valid, 1'b0);
        step();
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
